div_bus_master: RTL and testbench

Host-side initiator for the sequential restoring divider's start/ready/valid interface. Accepts operand pairs on an upstream valid/ready channel and holds them in a one-entry slot. Issues a single-cycle start to the divider, waits for completion under a timeout watchdog, and returns quotient, remainder and error flags on a downstream valid/ready channel. It sits between the bus fabric and the divider; the divider shares `clk` and `rst` with it.

---
 rtl/div_bus_pkg.sv | 15 +
 rtl/div_req_slot.sv | 33 +++
 rtl/div_bus_master.sv | 119 +++++++++++
 tb/tb_div_bus_master.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_bus_pkg.sv
// Shared definitions for the divider bus master: FSM state encoding and
// default operand width.
package div_bus_pkg;

    localparam int DIV_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        ARM,
        WAIT,
        RESP
    } div_bus_state_e;

endpackage

// File: rtl/div_req_slot.sv
// One-entry operand holding register. Contents stay stable until the slot is
// reloaded, so the divider sees constant operands for the whole operation.
module div_req_slot
    import div_bus_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] new_dividend,
    input  logic [WIDTH-1:0] new_divisor,
    output logic             full,
    output logic [WIDTH-1:0] dividend,
    output logic [WIDTH-1:0] divisor
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full     <= 1'b0;
            dividend <= '0;
            divisor  <= '0;
        end else if (load) begin
            full     <= 1'b1;
            dividend <= new_dividend;
            divisor  <= new_divisor;
        end else if (clear) begin
            full     <= 1'b0;
        end
    end

endmodule

// File: rtl/div_bus_master.sv
// Host-side initiator for the sequential divider: buffers one request, issues
// a start pulse, waits under a watchdog and returns the result downstream.
module div_bus_master
    import div_bus_pkg::*;
#(
    parameter int WIDTH   = DIV_WIDTH,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_dividend,
    input  logic [WIDTH-1:0] req_divisor,
    output logic [WIDTH-1:0] div_dividend,
    output logic [WIDTH-1:0] div_divisor,
    output logic             div_start,
    input  logic             div_ready,
    input  logic             div_valid,
    input  logic [WIDTH-1:0] div_q,
    input  logic [WIDTH-1:0] div_r,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_q,
    output logic [WIDTH-1:0] rsp_r,
    output logic             rsp_dbz,
    output logic             rsp_tmo,
    output logic             busy
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    div_bus_state_e  state;
    logic [CW-1:0]   cnt;
    logic            slot_full;
    logic            slot_load;
    logic            slot_clear;
    logic            expired;

    assign expired    = (cnt == LAST);
    assign slot_load  = req_valid & ~slot_full;
    // Operands must stay put until the divider is finished with them.
    assign slot_clear = (state == WAIT) & (div_ready | expired);
    assign req_ready  = ~slot_full;
    assign busy       = (state != IDLE);

    div_req_slot #(
        .WIDTH (WIDTH)
    ) u_slot (
        .clk          (clk),
        .rst          (rst),
        .load         (slot_load),
        .clear        (slot_clear),
        .new_dividend (req_dividend),
        .new_divisor  (req_divisor),
        .full         (slot_full),
        .dividend     (div_dividend),
        .divisor      (div_divisor)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            div_start <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_q     <= '0;
            rsp_r     <= '0;
            rsp_dbz   <= 1'b0;
            rsp_tmo   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (slot_full && div_ready) begin
                        div_start <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    div_start <= 1'b0;
                    state     <= ARM;
                end
                // The divider may still be showing the previous done here.
                ARM: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (div_ready) begin
                        rsp_q     <= div_q;
                        rsp_r     <= div_r;
                        rsp_dbz   <= ~div_valid;
                        rsp_tmo   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else if (expired) begin
                        rsp_q     <= '0;
                        rsp_r     <= '0;
                        rsp_dbz   <= 1'b0;
                        rsp_tmo   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_bus_master.sv
// Bench for div_bus_master: behavioural divider with fixed latency, expected
// results from plain arithmetic, protocol monitors on start/response.
module tb_div_bus_master;

    localparam int W   = 16;
    localparam int TMO = 64;
    localparam int LAT = 17;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [W-1:0] req_dividend = '0;
    logic [W-1:0] req_divisor = '0;
    logic [W-1:0] div_dividend;
    logic [W-1:0] div_divisor;
    logic         div_start;
    logic         div_ready;
    logic         div_valid;
    logic [W-1:0] div_q;
    logic [W-1:0] div_r;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] rsp_q;
    logic [W-1:0] rsp_r;
    logic         rsp_dbz;
    logic         rsp_tmo;
    logic         busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int start_cnt = 0;
    int bad_start = 0;
    int double_start = 0;
    int start_cyc = 0;
    int rsp_cyc = 0;
    logic pending;
    bit hang = 1'b0;
    bit hold_low = 1'b0;

    always #5 clk = ~clk;

    div_bus_master #(
        .WIDTH   (W),
        .TIMEOUT (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_dividend (req_dividend),
        .req_divisor  (req_divisor),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_start    (div_start),
        .div_ready    (div_ready),
        .div_valid    (div_valid),
        .div_q        (div_q),
        .div_r        (div_r),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_q        (rsp_q),
        .rsp_r        (rsp_r),
        .rsp_dbz      (rsp_dbz),
        .rsp_tmo      (rsp_tmo),
        .busy         (busy)
    );

    // Behavioural divider: latches operands on start, answers LAT cycles later.
    logic         dv_busy;
    int           dv_cnt;
    logic [W-1:0] dv_a, dv_b;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dv_busy   <= 1'b0;
            dv_cnt    <= 0;
            dv_a      <= '0;
            dv_b      <= '0;
            div_q     <= '0;
            div_r     <= '0;
            div_valid <= 1'b1;
        end else if (div_start && !dv_busy) begin
            dv_busy <= 1'b1;
            dv_cnt  <= LAT;
            dv_a    <= div_dividend;
            dv_b    <= div_divisor;
        end else if (dv_busy && !hang) begin
            if (dv_cnt == 1) begin
                dv_busy <= 1'b0;
                if (dv_b == 0) begin
                    div_valid <= 1'b0;
                    div_q     <= '1;
                    div_r     <= dv_a;
                end else begin
                    div_valid <= 1'b1;
                    div_q     <= dv_a / dv_b;
                    div_r     <= dv_a % dv_b;
                end
            end else begin
                dv_cnt <= dv_cnt - 1;
            end
        end
    end

    assign div_ready = !dv_busy && !hold_low;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= 1'b0;
        end else begin
            if (div_start) begin
                start_cnt <= start_cnt + 1;
                start_cyc <= cyc;
                if (!div_ready) bad_start <= bad_start + 1;
                if (pending) double_start <= double_start + 1;
                pending <= 1'b1;
            end
            if (rsp_valid && rsp_ready) pending <= 1'b0;
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (req_ready) begin
                req_valid    = 1'b1;
                req_dividend = a;
                req_divisor  = b;
                @(negedge clk);
                req_valid = 1'b0;
                ok = 1'b1;
            end
        end
    endtask

    task automatic wait_rsp(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim && !ok; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                ok = 1'b1;
                rsp_cyc = cyc;
            end
        end
    endtask

    task automatic take();
        @(negedge clk);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({req_ready, div_start, rsp_valid, rsp_dbz, rsp_tmo, busy} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_flags: got rr=%b st=%b rv=%b dbz=%b tmo=%b busy=%b, want 1 0 0 0 0 0",
                     req_ready, div_start, rsp_valid, rsp_dbz, rsp_tmo, busy);
        end
        checks++;
        if ({div_dividend, div_divisor, rsp_q, rsp_r} !== '0) begin
            errors++;
            $display("FAIL reset_data: got dd=%h dv=%h q=%h r=%h, want all 0",
                     div_dividend, div_divisor, rsp_q, rsp_r);
        end
    endtask

    task automatic test_basic();
        bit ok1, ok2;
        int s0;
        s0 = start_cnt;
        send(16'd100, 16'd7, ok1);
        wait_rsp(100, ok2);
        checks++;
        if (!(ok1 && ok2) || {rsp_q, rsp_r, rsp_dbz, rsp_tmo} !== {16'd14, 16'd2, 2'b00}
            || start_cnt - s0 != 1) begin
            errors++;
            $display("FAIL basic_100_7: got ok=%b%b q=%0d r=%0d dbz=%b tmo=%b starts=%0d, want ok=11 q=14 r=2 dbz=0 tmo=0 starts=1",
                     ok1, ok2, rsp_q, rsp_r, rsp_dbz, rsp_tmo, start_cnt - s0);
        end
        take();
    endtask

    task automatic test_dbz();
        bit ok1, ok2;
        send(16'h1234, 16'd0, ok1);
        wait_rsp(100, ok2);
        checks++;
        if (!(ok1 && ok2) || {rsp_dbz, rsp_tmo} !== 2'b10) begin
            errors++;
            $display("FAIL dbz: got ok=%b%b dbz=%b tmo=%b, want ok=11 dbz=1 tmo=0",
                     ok1, ok2, rsp_dbz, rsp_tmo);
        end
        take();
        checks++;
        if ({busy, rsp_valid} !== 2'b00) begin
            errors++;
            $display("FAIL dbz_idle: got busy=%b rv=%b, want 0 0", busy, rsp_valid);
        end
    endtask

    task automatic test_timeout();
        bit ok1, ok2;
        int lat;
        hang = 1'b1;
        send(16'd77, 16'd3, ok1);
        wait_rsp(TMO + 20, ok2);
        lat = rsp_cyc - start_cyc;
        checks++;
        if (!(ok1 && ok2) || {rsp_q, rsp_r, rsp_dbz, rsp_tmo} !== {16'd0, 16'd0, 2'b01}) begin
            errors++;
            $display("FAIL timeout: got ok=%b%b q=%0d r=%0d dbz=%b tmo=%b, want ok=11 q=0 r=0 dbz=0 tmo=1",
                     ok1, ok2, rsp_q, rsp_r, rsp_dbz, rsp_tmo);
        end
        checks++;
        if (lat < TMO || lat > TMO + 3) begin
            errors++;
            $display("FAIL timeout_latency: got %0d cycles start->rsp, want %0d..%0d", lat, TMO, TMO + 3);
        end
        take();
        hang = 1'b0;
        send(16'd50, 16'd5, ok1);
        wait_rsp(100, ok2);
        checks++;
        if (!(ok1 && ok2) || {rsp_q, rsp_r, rsp_dbz, rsp_tmo} !== {16'd10, 16'd0, 2'b00}) begin
            errors++;
            $display("FAIL after_timeout_50_5: got ok=%b%b q=%0d r=%0d dbz=%b tmo=%b, want ok=11 q=10 r=0 dbz=0 tmo=0",
                     ok1, ok2, rsp_q, rsp_r, rsp_dbz, rsp_tmo);
        end
        take();
    endtask

    task automatic test_back_to_back();
        bit ok1, ok2, ok3;
        int s0;
        s0 = start_cnt;
        send(16'd65535, 16'd255, ok1);
        wait_rsp(100, ok2);
        send(16'd9, 16'd4, ok3);
        checks++;
        if (!(ok1 && ok2 && ok3) || {rsp_valid, req_ready} !== 2'b10) begin
            errors++;
            $display("FAIL b2b_accept_in_resp: got ok=%b%b%b rv=%b rr=%b, want ok=111 rv=1 rr=0",
                     ok1, ok2, ok3, rsp_valid, req_ready);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (start_cnt - s0 != 1 || {rsp_valid, rsp_q, rsp_r} !== {1'b1, 16'd257, 16'd0}) begin
            errors++;
            $display("FAIL b2b_first: got starts=%0d rv=%b q=%0d r=%0d, want starts=1 rv=1 q=257 r=0",
                     start_cnt - s0, rsp_valid, rsp_q, rsp_r);
        end
        take();
        wait_rsp(100, ok2);
        checks++;
        if (!ok2 || start_cnt - s0 != 2 || {rsp_q, rsp_r, rsp_dbz, rsp_tmo} !== {16'd2, 16'd1, 2'b00}) begin
            errors++;
            $display("FAIL b2b_second: got ok=%b starts=%0d q=%0d r=%0d dbz=%b tmo=%b, want ok=1 starts=2 q=2 r=1 dbz=0 tmo=0",
                     ok2, start_cnt - s0, rsp_q, rsp_r, rsp_dbz, rsp_tmo);
        end
        take();
    endtask

    task automatic test_reset_mid();
        bit ok1, seen;
        int s0;
        s0 = start_cnt;
        send(16'd1000, 16'd3, ok1);
        for (int i = 0; i < 50 && start_cnt == s0; i++) @(negedge clk);
        repeat (6) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (!ok1 || {req_ready, div_start, rsp_valid, rsp_dbz, rsp_tmo, busy} !== 6'b100000
            || {div_dividend, div_divisor, rsp_q, rsp_r} !== '0) begin
            errors++;
            $display("FAIL reset_async: got ok=%b rr=%b st=%b rv=%b dbz=%b tmo=%b busy=%b dd=%h dv=%h q=%h r=%h, want ok=1 1 0 0 0 0 0 and data 0",
                     ok1, req_ready, div_start, rsp_valid, rsp_dbz, rsp_tmo, busy,
                     div_dividend, div_divisor, rsp_q, rsp_r);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        checks++;
        if (seen || start_cnt - s0 != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_drop: got rsp_seen=%b starts=%0d busy=%b, want 0 1 0",
                     seen, start_cnt - s0, busy);
        end
    endtask

    task automatic test_ready_gate();
        bit ok1, ok2;
        int s0;
        s0 = start_cnt;
        hold_low = 1'b1;
        send(16'd5, 16'd2, ok1);
        repeat (8) @(negedge clk);
        checks++;
        if (!ok1 || start_cnt != s0 || {busy, req_ready} !== 2'b00) begin
            errors++;
            $display("FAIL gate_hold: got ok=%b starts=%0d busy=%b rr=%b, want 1 0 0 0",
                     ok1, start_cnt - s0, busy, req_ready);
        end
        hold_low = 1'b0;
        wait_rsp(100, ok2);
        checks++;
        if (!ok2 || start_cnt - s0 != 1 || {rsp_q, rsp_r, rsp_dbz, rsp_tmo} !== {16'd2, 16'd1, 2'b00}) begin
            errors++;
            $display("FAIL gate_release: got ok=%b starts=%0d q=%0d r=%0d dbz=%b tmo=%b, want 1 1 2 1 0 0",
                     ok2, start_cnt - s0, rsp_q, rsp_r, rsp_dbz, rsp_tmo);
        end
        take();
    endtask

    task automatic test_random();
        bit ok1, ok2;
        logic [W-1:0] a, b;
        logic [2*W+1:0] exp_v, got_v;
        for (int n = 0; n < 24; n++) begin
            a = W'($urandom);
            b = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
            send(a, b, ok1);
            wait_rsp(100, ok2);
            if (b == 0) begin
                exp_v = {16'd0, 16'd0, 2'b10};
                got_v = {16'd0, 16'd0, rsp_dbz, rsp_tmo};
            end else begin
                exp_v = {a / b, a % b, 2'b00};
                got_v = {rsp_q, rsp_r, rsp_dbz, rsp_tmo};
            end
            checks++;
            if (!(ok1 && ok2) || got_v !== exp_v) begin
                errors++;
                $display("FAIL random_%0d: %0d/%0d got ok=%b%b q=%0d r=%0d dbz=%b tmo=%b, want q=%0d r=%0d dbz=%b",
                         n, a, b, ok1, ok2, rsp_q, rsp_r, rsp_dbz, rsp_tmo,
                         exp_v[2*W+1:W+2], exp_v[W+1:2], exp_v[1]);
            end
            repeat ($urandom_range(0, 4)) @(negedge clk);
            take();
        end
    endtask

    task automatic test_protocol();
        checks++;
        if (bad_start != 0 || double_start != 0) begin
            errors++;
            $display("FAIL protocol: got start_without_ready=%0d double_start=%0d, want 0 0",
                     bad_start, double_start);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_dbz();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_ready_gate();
        test_random();
        test_protocol();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
